// File: rtl/fu_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fu_addsub_pipe
//   Pipelined add/sub/set-less-than functional unit for the Tomasulo core.
//   Takes one op per cycle from the add/sub reservation stations, computes
//   the result combinationally at issue, and carries it (with destination,
//   reservation-station label and flags) down LATENCY register stages.
//   The last stage drives the common data bus.
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous active-low reset
//     flush        synchronous squash of every in-flight op
//     issue_valid  issue request
//     issue_ready  unit accepts an op this cycle
//     issue_op     000 ADD, 001 SUB, 010 SLT (signed), others illegal
//     issue_x/y    operands
//     issue_dest   destination register address
//     issue_tag    reservation-station label
//     cdb_valid    result present on the CDB
//     cdb_ready    CDB consumes the result
//     cdb_result   result (0 when idle or illegal)
//     cdb_dest     destination of the result
//     cdb_tag      label of the result
//     cdb_ovf      signed overflow (ADD/SUB)
//     cdb_carry    ADD carry-out / SUB borrow
//     cdb_illegal  op code was not recognised
//     inflight     number of valid pipeline stages
//     busy         inflight != 0
//
//   Handshake: a transfer happens on a rising edge where valid & ready are
//   both 1. On the issue side, issue_ready = ~(cdb_valid & ~cdb_ready), which
//   is combinational from cdb_ready. On the CDB side, cdb_valid and all cdb_*
//   payload stay stable while cdb_ready=0; once the handshake completes the
//   next stage (or zeros) is presented.
// ---------------------------------------------------------------------------
module fu_addsub_pipe #(
  parameter int WIDTH   = 9,
  parameter int LATENCY = 3,
  parameter int DEST_W  = 3,
  parameter int TAG_W   = 3,
  parameter int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_op,
  input  logic [WIDTH-1:0]  issue_x,
  input  logic [WIDTH-1:0]  issue_y,
  input  logic [DEST_W-1:0] issue_dest,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic              cdb_valid,
  input  logic              cdb_ready,
  output logic [WIDTH-1:0]  cdb_result,
  output logic [DEST_W-1:0] cdb_dest,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic              cdb_ovf,
  output logic              cdb_carry,
  output logic              cdb_illegal,
  output logic [CNT_W-1:0]  inflight,
  output logic              busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;

  // Payload carried by each pipeline stage; the valid bit lives separately
  // so that flush only has to clear one vector.
  typedef struct packed {
    logic [WIDTH-1:0]  res;
    logic [DEST_W-1:0] dest;
    logic [TAG_W-1:0]  tag;
    logic              ovf;
    logic              carry;
    logic              ill;
  } stage_t;

  logic [LATENCY-1:0] r_vld;
  stage_t             r_stg [LATENCY];
  logic [CNT_W-1:0]   r_cnt;

  logic               w_stall;
  logic               w_accept;
  logic               w_handshake;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic               w_lt;
  stage_t             w_new;

  // ---------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------
  assign w_stall     = r_vld[LATENCY-1] & ~cdb_ready;
  assign issue_ready = ~w_stall;
  assign w_accept    = issue_valid & ~w_stall;
  assign w_handshake = r_vld[LATENCY-1] & cdb_ready;

  // ---------------------------------------------------------------------
  // Issue-time arithmetic
  // ---------------------------------------------------------------------
  // Zero-extended to WIDTH+1 so the top bit is carry (ADD) or borrow (SUB).
  assign w_sum = {1'b0, issue_x} + {1'b0, issue_y};
  assign w_dif = {1'b0, issue_x} - {1'b0, issue_y};
  assign w_lt  = $signed(issue_x) < $signed(issue_y);

  always_comb begin
    w_new       = '0;
    w_new.dest  = issue_dest;
    w_new.tag   = issue_tag;
    case (issue_op)
      OP_ADD: begin
        w_new.res   = w_sum[WIDTH-1:0];
        w_new.carry = w_sum[WIDTH];
        w_new.ovf   = (issue_x[WIDTH-1] == issue_y[WIDTH-1]) &
                      (w_sum[WIDTH-1] != issue_x[WIDTH-1]);
      end
      OP_SUB: begin
        w_new.res   = w_dif[WIDTH-1:0];
        w_new.carry = w_dif[WIDTH];
        w_new.ovf   = (issue_x[WIDTH-1] != issue_y[WIDTH-1]) &
                      (w_dif[WIDTH-1] != issue_x[WIDTH-1]);
      end
      OP_SLT: begin
        w_new.res   = WIDTH'(w_lt);
      end
      default: begin
        // Illegal op: only the routing information survives.
        w_new.ill   = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Pipeline stages and in-flight counter
  // ---------------------------------------------------------------------
  // Every stage shifts together or holds together; no bubble compression,
  // so an empty stage ahead of a stalled head does not absorb anything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      r_cnt <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_stg[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over stall, handshake and a same-cycle issue.
      r_vld <= '0;
      r_cnt <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= w_accept;
      r_stg[0] <= w_accept ? w_new : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_stg[i] <= r_stg[i-1];
      end
      case ({w_accept, w_handshake})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // With every stage full the head is valid, so a non-stalled cycle always
  // retires one op; the counter therefore cannot pass LATENCY.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (r_cnt <= CNT_W'(LATENCY));
    end
  end

  // ---------------------------------------------------------------------
  // CDB outputs (zeroed when the head stage is empty, e.g. after flush)
  // ---------------------------------------------------------------------
  assign cdb_valid   = r_vld[LATENCY-1];
  assign cdb_result  = cdb_valid ? r_stg[LATENCY-1].res   : '0;
  assign cdb_dest    = cdb_valid ? r_stg[LATENCY-1].dest  : '0;
  assign cdb_tag     = cdb_valid ? r_stg[LATENCY-1].tag   : '0;
  assign cdb_ovf     = cdb_valid & r_stg[LATENCY-1].ovf;
  assign cdb_carry   = cdb_valid & r_stg[LATENCY-1].carry;
  assign cdb_illegal = cdb_valid & r_stg[LATENCY-1].ill;

  assign inflight    = r_cnt;
  assign busy        = (r_cnt != '0);

endmodule

// File: tb/tb_fu_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_fu_addsub_pipe
//   Directed bench for fu_addsub_pipe with WIDTH=9, LATENCY=3.
//   A table of hand-computed vectors is issued back to back; a CDB monitor
//   pops the expected queue on every handshake. Hand-written sequences cover
//   latency, backpressure, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_fu_addsub_pipe;

  localparam int WIDTH   = 9;
  localparam int LATENCY = 3;
  localparam int DEST_W  = 3;
  localparam int TAG_W   = 3;
  localparam int CNT_W   = 2;
  localparam int EW      = WIDTH + DEST_W + TAG_W + 3;
  localparam int NVEC    = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        issue_op;
  logic [WIDTH-1:0]  issue_x;
  logic [WIDTH-1:0]  issue_y;
  logic [DEST_W-1:0] issue_dest;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic              cdb_ready;
  logic [WIDTH-1:0]  cdb_result;
  logic [DEST_W-1:0] cdb_dest;
  logic [TAG_W-1:0]  cdb_tag;
  logic              cdb_ovf;
  logic              cdb_carry;
  logic              cdb_illegal;
  logic [CNT_W-1:0]  inflight;
  logic              busy;

  fu_addsub_pipe #(
    .WIDTH(WIDTH), .LATENCY(LATENCY), .DEST_W(DEST_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_x(issue_x), .issue_y(issue_y), .issue_dest(issue_dest), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_result(cdb_result),
    .cdb_dest(cdb_dest), .cdb_tag(cdb_tag), .cdb_ovf(cdb_ovf), .cdb_carry(cdb_carry),
    .cdb_illegal(cdb_illegal), .inflight(inflight), .busy(busy)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]        op;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic [DEST_W-1:0] dest;
    logic [TAG_W-1:0]  tag;
    logic [WIDTH-1:0]  res;
    logic              ovf;
    logic              carry;
    logic              ill;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [2:0] op, input logic [WIDTH-1:0] x,
                              input logic [WIDTH-1:0] y, input logic [DEST_W-1:0] d,
                              input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] r,
                              input logic o, input logic c, input logic il);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.dest = d; v.tag = t;
    v.res = r; v.ovf = o; v.carry = c; v.ill = il;
    return v;
  endfunction

  function automatic logic [EW-1:0] pack_exp(input vec_t v);
    return {v.res, v.dest, v.tag, v.ovf, v.carry, v.ill};
  endfunction

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare on the falling edge: a handshake seen here completes at the
  // next rising edge, since inputs only change just after rising edges.
  always @(negedge clk) begin
    if (reset && cdb_valid && cdb_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL cdb_unexpected: got result 0x%0h dest %0d tag %0d, expected no output",
                 cdb_result, cdb_dest, cdb_tag);
      end else begin
        check("cdb_out",
              32'({cdb_result, cdb_dest, cdb_tag, cdb_ovf, cdb_carry, cdb_illegal}),
              32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v, input bit track);
    issue_valid = 1'b1;
    issue_op    = v.op;
    issue_x     = v.x;
    issue_y     = v.y;
    issue_dest  = v.dest;
    issue_tag   = v.tag;
    if (track) begin
      check("issue_ready_at_issue", 32'(issue_ready), 32'd1);
      exp_q.push_back(pack_exp(v));
    end
    tick();
    issue_valid = 1'b0;
  endtask

  int peak;

  initial begin
    flush = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_x = '0; issue_y = '0;
    issue_dest = '0; issue_tag = '0; cdb_ready = 1'b1;

    //            op      x       y       d  t  res     ovf   carry ill
    vecs[0]  = mk(3'b000, 9'd100, 9'd27,  2, 5, 9'd127, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(3'b001, 9'h0FF, 9'h100, 1, 1, 9'h1FF, 1'b1, 1'b1, 1'b0);
    vecs[2]  = mk(3'b000, 9'h1FF, 9'h001, 3, 6, 9'h000, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(3'b000, 9'h0FF, 9'h001, 4, 2, 9'h100, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(3'b001, 9'h005, 9'h003, 5, 3, 9'h002, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(3'b001, 9'h003, 9'h005, 6, 4, 9'h1FE, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mk(3'b001, 9'h100, 9'h001, 7, 7, 9'h0FF, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(3'b010, 9'h1FF, 9'h001, 0, 0, 9'h001, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(3'b010, 9'h001, 9'h1FF, 1, 2, 9'h000, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(3'b010, 9'h100, 9'h0FF, 2, 3, 9'h001, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(3'b010, 9'h005, 9'h005, 3, 4, 9'h000, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(3'b111, 9'h007, 9'h009, 4, 5, 9'h000, 1'b0, 1'b0, 1'b1);
    vecs[12] = mk(3'b011, 9'h1FF, 9'h1FF, 5, 6, 9'h000, 1'b0, 1'b0, 1'b1);
    vecs[13] = mk(3'b000, 9'h100, 9'h100, 6, 7, 9'h000, 1'b1, 1'b1, 1'b0);

    // ---- reset state ----
    repeat (3) tick();
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cdb_result", 32'(cdb_result), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    tick();

    // ---- single ADD: latency and payload ----
    issue(vecs[0], 1'b1);
    check("lat_after_e0_valid", 32'(cdb_valid), 32'd0);
    check("lat_after_e0_inflight", 32'(inflight), 32'd1);
    check("lat_after_e0_busy", 32'(busy), 32'd1);
    tick();
    check("lat_after_e1_valid", 32'(cdb_valid), 32'd0);
    tick();
    check("lat_after_e2_valid", 32'(cdb_valid), 32'd1);
    check("lat_result", 32'(cdb_result), 32'd127);
    check("lat_dest", 32'(cdb_dest), 32'd2);
    check("lat_tag", 32'(cdb_tag), 32'd5);
    tick();
    check("lat_drained_valid", 32'(cdb_valid), 32'd0);
    check("lat_drained_inflight", 32'(inflight), 32'd0);

    // ---- table, back to back with cdb_ready=1 ----
    peak = 0;
    for (int i = 1; i < NVEC; i++) begin
      issue(vecs[i], 1'b1);
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    for (int i = 0; i <= LATENCY; i++) tick();
    check("b2b_inflight_peak", 32'(peak), 32'd3);
    check("b2b_inflight_end", 32'(inflight), 32'd0);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---- backpressure ----
    cdb_ready = 1'b0;
    issue(vecs[1], 1'b1);
    issue(vecs[4], 1'b1);
    issue(vecs[7], 1'b1);
    check("bp_issue_ready", 32'(issue_ready), 32'd0);
    check("bp_inflight", 32'(inflight), 32'd3);
    check("bp_valid", 32'(cdb_valid), 32'd1);
    check("bp_result", 32'(cdb_result), 32'(vecs[1].res));
    // Attempted issue while stalled must be refused.
    issue_valid = 1'b1; issue_op = 3'b000; issue_x = 9'd3; issue_y = 9'd4;
    tick();
    tick();
    issue_valid = 1'b0;
    check("bp_hold_result", 32'(cdb_result), 32'(vecs[1].res));
    check("bp_hold_dest", 32'(cdb_dest), 32'(vecs[1].dest));
    check("bp_hold_ovf", 32'(cdb_ovf), 32'd1);
    check("bp_hold_inflight", 32'(inflight), 32'd3);
    cdb_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(issue_ready), 32'd1);
    repeat (LATENCY) tick();
    check("bp_drain_inflight", 32'(inflight), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---- flush with two ops in flight plus a same-cycle issue ----
    issue(vecs[2], 1'b0);
    issue(vecs[3], 1'b0);
    check("fl_pre_inflight", 32'(inflight), 32'd2);
    flush = 1'b1;
    issue(vecs[5], 1'b0);
    flush = 1'b0;
    check("fl_inflight", 32'(inflight), 32'd0);
    check("fl_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("fl_no_valid", 32'(cdb_valid), 32'd0);
      tick();
    end

    // ---- async reset mid-pipeline ----
    cdb_ready = 1'b0;
    issue(vecs[4], 1'b0);
    issue(vecs[5], 1'b0);
    issue(vecs[6], 1'b0);
    check("ar_pre_valid", 32'(cdb_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", 32'(cdb_valid), 32'd0);
    check("ar_inflight", 32'(inflight), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    cdb_ready = 1'b1;
    #1;
    check("ar_issue_ready", 32'(issue_ready), 32'd1);
    tick();
    issue(mk(3'b000, 9'd1, 9'd1, 3, 2, 9'd2, 1'b0, 1'b0, 1'b0), 1'b1);
    repeat (LATENCY) tick();
    check("ar_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ar_inflight_end", 32'(inflight), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
